// File: rtl/filtro_convolucion_5x5.sv
// -----------------------------------------------------------------------------
// filtro_convolucion_5x5
// Programmable signed 5x5 convolution on a stream of pixel windows.
// A small load FSM receives the 25 kernel coefficients serially (k = 1..25)
// together with a normalisation shift. Once the kernel is complete, every valid
// window is pushed through a fixed-latency pipeline: input capture, products,
// row sums, total sum, then rounding shift with saturation into pixel_salida.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   ventana_valida        : pixel_1..pixel_25 carry a window this cycle
//   pixel_1 .. pixel_25   : unsigned window pixels, coefficient k weights pixel_k
//   cargar_coef           : pulse that starts/restarts a coefficient load
//   coef_valido, coef_in  : serial signed coefficient stream during a load
//   corrimiento           : right-shift amount, latched with cargar_coef
//   coef_listos           : kernel complete, windows are accepted
//   pixel_salida          : filtered pixel (holds when salida_valida is low)
//   salida_valida         : pixel_salida carries a new result this cycle
// -----------------------------------------------------------------------------
module filtro_convolucion_5x5 #(
    parameter int BITS_PIXEL = 8,
    parameter int BITS_COEF  = 8,
    parameter int BITS_SHIFT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ventana_valida,
    input  logic [BITS_PIXEL-1:0]        pixel_1,
    input  logic [BITS_PIXEL-1:0]        pixel_2,
    input  logic [BITS_PIXEL-1:0]        pixel_3,
    input  logic [BITS_PIXEL-1:0]        pixel_4,
    input  logic [BITS_PIXEL-1:0]        pixel_5,
    input  logic [BITS_PIXEL-1:0]        pixel_6,
    input  logic [BITS_PIXEL-1:0]        pixel_7,
    input  logic [BITS_PIXEL-1:0]        pixel_8,
    input  logic [BITS_PIXEL-1:0]        pixel_9,
    input  logic [BITS_PIXEL-1:0]        pixel_10,
    input  logic [BITS_PIXEL-1:0]        pixel_11,
    input  logic [BITS_PIXEL-1:0]        pixel_12,
    input  logic [BITS_PIXEL-1:0]        pixel_13,
    input  logic [BITS_PIXEL-1:0]        pixel_14,
    input  logic [BITS_PIXEL-1:0]        pixel_15,
    input  logic [BITS_PIXEL-1:0]        pixel_16,
    input  logic [BITS_PIXEL-1:0]        pixel_17,
    input  logic [BITS_PIXEL-1:0]        pixel_18,
    input  logic [BITS_PIXEL-1:0]        pixel_19,
    input  logic [BITS_PIXEL-1:0]        pixel_20,
    input  logic [BITS_PIXEL-1:0]        pixel_21,
    input  logic [BITS_PIXEL-1:0]        pixel_22,
    input  logic [BITS_PIXEL-1:0]        pixel_23,
    input  logic [BITS_PIXEL-1:0]        pixel_24,
    input  logic [BITS_PIXEL-1:0]        pixel_25,
    input  logic                         cargar_coef,
    input  logic                         coef_valido,
    input  logic signed [BITS_COEF-1:0]  coef_in,
    input  logic [BITS_SHIFT-1:0]        corrimiento,
    output logic                         coef_listos,
    output logic [BITS_PIXEL-1:0]        pixel_salida,
    output logic                         salida_valida
);

    localparam int N_TAPS = 25;
    localparam int N_ROWS = 5;
    localparam int N_COLS = 5;
    localparam int PW     = BITS_PIXEL + BITS_COEF + 1;  // product width
    localparam int RW     = PW + 3;                      // row-sum width
    localparam int TW     = PW + 5;                      // total-sum width

    localparam logic [BITS_SHIFT-1:0] SHIFT_CERO = {BITS_SHIFT{1'b0}};
    localparam logic [BITS_SHIFT-1:0] SHIFT_UNO  = {{(BITS_SHIFT-1){1'b0}}, 1'b1};
    localparam logic signed [TW:0]    UNO_EXT    = {{TW{1'b0}}, 1'b1};
    localparam logic signed [TW:0]    SAT_MAX    = {{(TW+1-BITS_PIXEL){1'b0}}, {BITS_PIXEL{1'b1}}};
    localparam logic [4:0]            IDX_ULTIMO = 5'd24;

    typedef enum logic [1:0] {
        SIN_CONFIG = 2'd0,
        CARGANDO   = 2'd1,
        LISTO      = 2'd2
    } estado_t;

    // Zero-extend the pixel, sign-extend the coefficient, multiply at full width.
    function automatic logic signed [PW-1:0] producto(
        input logic [BITS_PIXEL-1:0]       p,
        input logic signed [BITS_COEF-1:0] c
    );
        logic signed [PW-1:0] pe;
        logic signed [PW-1:0] ce;
        pe = {{(PW-BITS_PIXEL){1'b0}}, p};
        ce = {{(PW-BITS_COEF){c[BITS_COEF-1]}}, c};
        return pe * ce;
    endfunction

    estado_t                       estado_r;
    estado_t                       estado_next_s;
    logic [4:0]                    idx_r;
    logic [4:0]                    idx_next_s;
    logic [BITS_SHIFT-1:0]         shift_r;
    logic [BITS_SHIFT-1:0]         shift_next_s;
    logic                          wr_coef_s;
    logic                          coef_listos_r;
    logic signed [BITS_COEF-1:0]   coef_r [0:N_TAPS-1];
    logic [BITS_PIXEL-1:0]         pix_s  [0:N_TAPS-1];
    logic                          acepta_s;

    // Pipeline state: valid bits (reset) and data (free-running)
    logic                          v0_r, v1_r, v2_r, v3_r, salida_valida_r;
    logic [BITS_PIXEL-1:0]         pix0_r [0:N_TAPS-1];
    logic signed [PW-1:0]          prod_r [0:N_TAPS-1];
    logic signed [RW-1:0]          row_s  [0:N_ROWS-1];
    logic signed [RW-1:0]          row_r  [0:N_ROWS-1];
    logic signed [TW-1:0]          sum_s;
    logic signed [TW-1:0]          sum_r;
    logic [BITS_SHIFT-1:0]         sh0_r, sh1_r, sh2_r, sh3_r;
    logic signed [TW:0]            ext_s;
    logic signed [TW:0]            rnd_s;
    logic signed [TW:0]            res_s;
    logic [BITS_PIXEL-1:0]         sat_s;
    logic [BITS_PIXEL-1:0]         pixel_salida_r;

    assign pix_s = '{pixel_1,  pixel_2,  pixel_3,  pixel_4,  pixel_5,
                     pixel_6,  pixel_7,  pixel_8,  pixel_9,  pixel_10,
                     pixel_11, pixel_12, pixel_13, pixel_14, pixel_15,
                     pixel_16, pixel_17, pixel_18, pixel_19, pixel_20,
                     pixel_21, pixel_22, pixel_23, pixel_24, pixel_25};

    // Load FSM state, index, latched shift and registered ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r      <= SIN_CONFIG;
            idx_r         <= 5'd0;
            shift_r       <= SHIFT_CERO;
            coef_listos_r <= 1'b0;
        end else begin
            estado_r      <= estado_next_s;
            idx_r         <= idx_next_s;
            shift_r       <= shift_next_s;
            coef_listos_r <= (estado_next_s == LISTO);
        end
    end

    // Load FSM next state; cargar_coef always wins over a coefficient write
    always_comb begin
        estado_next_s = estado_r;
        idx_next_s    = idx_r;
        shift_next_s  = shift_r;
        wr_coef_s     = 1'b0;
        case (estado_r)
            SIN_CONFIG, LISTO: begin
                if (cargar_coef) begin
                    estado_next_s = CARGANDO;
                    idx_next_s    = 5'd0;
                    shift_next_s  = corrimiento;
                end else begin
                    estado_next_s = estado_r;
                end
            end
            CARGANDO: begin
                if (cargar_coef) begin
                    idx_next_s   = 5'd0;
                    shift_next_s = corrimiento;
                end else if (coef_valido) begin
                    wr_coef_s = 1'b1;
                    if (idx_r == IDX_ULTIMO) begin
                        estado_next_s = LISTO;
                        idx_next_s    = 5'd0;
                    end else begin
                        idx_next_s = idx_r + 5'd1;
                    end
                end else begin
                    idx_next_s = idx_r;
                end
            end
            default: begin
                estado_next_s = SIN_CONFIG;
                idx_next_s    = 5'd0;
            end
        endcase
    end

    // Coefficient store, written serially during a load
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 32'sd0; k < N_TAPS; k++) begin
                coef_r[k] <= {BITS_COEF{1'b0}};
            end
        end else if (wr_coef_s) begin
            coef_r[idx_r] <= coef_in;
        end
    end

    // A window is taken only while the registered state says the kernel is complete
    assign acepta_s = ventana_valida && (estado_r == LISTO);

    // Valid bits travel with each window; cleared by reset so in-flight work is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_r            <= 1'b0;
            v1_r            <= 1'b0;
            v2_r            <= 1'b0;
            v3_r            <= 1'b0;
            salida_valida_r <= 1'b0;
        end else begin
            v0_r            <= acepta_s;
            v1_r            <= v0_r;
            v2_r            <= v1_r;
            v3_r            <= v2_r;
            salida_valida_r <= v3_r;
        end
    end

    // Row sums of the registered products, sign-extended before adding
    always_comb begin
        for (int r = 32'sd0; r < N_ROWS; r++) begin
            row_s[r] = {RW{1'b0}};
            for (int c = 32'sd0; c < N_COLS; c++) begin
                row_s[r] = row_s[r]
                         + {{3{prod_r[r*N_COLS+c][PW-1]}}, prod_r[r*N_COLS+c]};
            end
        end
    end

    // Total of the five row sums
    always_comb begin
        sum_s = {TW{1'b0}};
        for (int r = 32'sd0; r < N_ROWS; r++) begin
            sum_s = sum_s + {{2{row_r[r][RW-1]}}, row_r[r]};
        end
    end

    // Data pipeline; the shift rides along so a reload never affects older windows
    always_ff @(posedge clk) begin
        pix0_r <= pix_s;
        sh0_r  <= shift_r;
        for (int k = 32'sd0; k < N_TAPS; k++) begin
            prod_r[k] <= producto(pix0_r[k], coef_r[k]);
        end
        sh1_r <= sh0_r;
        row_r <= row_s;
        sh2_r <= sh1_r;
        sum_r <= sum_s;
        sh3_r <= sh2_r;
    end

    // Round-half-up arithmetic shift, then clamp to the unsigned pixel range
    always_comb begin
        ext_s = {sum_r[TW-1], sum_r};
        rnd_s = ext_s;
        if (sh3_r != SHIFT_CERO) begin
            rnd_s = ext_s + (UNO_EXT << (sh3_r - SHIFT_UNO));
            res_s = rnd_s >>> sh3_r;
        end else begin
            res_s = ext_s;
        end
        if (res_s[TW]) begin
            sat_s = {BITS_PIXEL{1'b0}};
        end else if (res_s > SAT_MAX) begin
            sat_s = {BITS_PIXEL{1'b1}};
        end else begin
            sat_s = res_s[BITS_PIXEL-1:0];
        end
    end

    // Output pixel register; holds its value between valid results
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_salida_r <= {BITS_PIXEL{1'b0}};
        end else if (v3_r) begin
            pixel_salida_r <= sat_s;
        end
    end

    assign coef_listos   = coef_listos_r;
    assign pixel_salida  = pixel_salida_r;
    assign salida_valida = salida_valida_r;

endmodule
